vga_sync_analyzer: RTL

VGA_SYNC_ANALYZER -- requirements
Module: vga_sync_analyzer

---
 rtl/vga_sync_analyzer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_analyzer.sv
// vga_sync_analyzer
//   Measures an incoming VGA sync stream (line period, hsync width, lines per
//   frame), decides whether it matches the expected HTOTAL x VTOTAL timing,
//   and optionally counts lit pixels per frame.
//
//   Optional feature macro: VGA_SYNC_ANALYZER_PIXCNT_EN
//     defined   -> lit-pixel counter present, pixcnt_o reports it per frame
//     undefined -> pixcnt_o is tied to 0, no counter is built
//
// Ports
//   clk_i                  single clock, all inputs synchronous to it
//   rst_i                  asynchronous active-high reset
//   hsync_i, vsync_i       incoming syncs (polarity set by SYNC_ACTIVE_LOW)
//   red_i, green_i, blue_i incoming colour bits
//   hperiod_o  [10:0]      last measured line period, clocks
//   hpulse_o   [10:0]      last measured hsync asserted width, clocks
//   vlines_o   [9:0]       last measured frame length, lines
//   frame_o                one-cycle pulse per evaluated frame
//   locked_o               timing matches HTOTAL/VTOTAL
//   pixcnt_o   [18:0]      lit pixels in the last frame
module vga_sync_analyzer #(
    parameter int HTOTAL          = 800,
    parameter int VTOTAL          = 525,
    parameter int LOCK_FRAMES     = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        red_i,
    input  logic        green_i,
    input  logic        blue_i,
    output logic [10:0] hperiod_o,
    output logic [10:0] hpulse_o,
    output logic [9:0]  vlines_o,
    output logic        frame_o,
    output logic        locked_o,
    output logic [18:0] pixcnt_o
);

    localparam logic [10:0] HT = 11'(HTOTAL);
    localparam logic [9:0]  VT = 10'(VTOTAL);
    localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // ---------------- sync input stage ----------------
    logic hs_in, vs_in;
    logic hs_r, hs_p, vs_r, vs_p;
    logic hs_edge, hs_fall, vs_edge;

    assign hs_in = (SYNC_ACTIVE_LOW != 0) ? ~hsync_i : hsync_i;
    assign vs_in = (SYNC_ACTIVE_LOW != 0) ? ~vsync_i : vsync_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_r <= 1'b0;
            hs_p <= 1'b0;
            vs_r <= 1'b0;
            vs_p <= 1'b0;
        end else begin
            hs_r <= hs_in;
            hs_p <= hs_r;
            vs_r <= vs_in;
            vs_p <= vs_r;
        end
    end

    assign hs_edge = hs_r & ~hs_p;
    assign hs_fall = ~hs_r & hs_p;
    assign vs_edge = vs_r & ~vs_p;

    // ---------------- horizontal / vertical measurement ----------------
    logic [10:0] hcnt, pcnt;
    logic [9:0]  lcnt, lcnt_inc;
    logic        h_seen, line_err;
    logic        lost, period_bad, frame_match;

    // A saturated hcnt with no fresh edge means the hsync stream is gone.
    assign lost       = (hcnt == 11'h7FF) & ~hs_edge;
    assign period_bad = hs_edge & h_seen & (hcnt != HT);
    // A line ending on the vsync edge still belongs to the frame that ends.
    assign lcnt_inc   = (hs_edge && lcnt != 10'h3FF) ? lcnt + 10'd1 : lcnt;
    assign frame_match = (lcnt_inc == VT) & ~(line_err | period_bad);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt      <= '0;
            pcnt      <= '0;
            lcnt      <= '0;
            h_seen    <= 1'b0;
            line_err  <= 1'b0;
            hperiod_o <= '0;
            hpulse_o  <= '0;
            vlines_o  <= '0;
        end else begin
            if (hs_edge)
                hcnt <= 11'd1;
            else if (hcnt != 11'h7FF)
                hcnt <= hcnt + 11'd1;

            // First edge after reset or sync loss has no predecessor to measure.
            if (lost)
                h_seen <= 1'b0;
            else if (hs_edge)
                h_seen <= 1'b1;

            if (hs_edge && h_seen)
                hperiod_o <= hcnt;

            if (hs_r) begin
                if (pcnt != 11'h7FF)
                    pcnt <= pcnt + 11'd1;
            end else if (hs_fall) begin
                hpulse_o <= pcnt;
                pcnt     <= '0;
            end

            if (vs_edge) begin
                vlines_o <= lcnt_inc;
                lcnt     <= '0;
                line_err <= 1'b0;
            end else begin
                lcnt     <= lcnt_inc;
                line_err <= line_err | period_bad;
            end
        end
    end

    // ---------------- lock FSM ----------------
    state_t     state, state_n;
    logic [3:0] mcnt, mcnt_n;
    logic       frame_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= SEARCH;
            mcnt     <= '0;
            frame_o  <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            state    <= state_n;
            mcnt     <= mcnt_n;
            frame_o  <= frame_n;
            locked_o <= (state == LOCKED);
        end
    end

    always_comb begin
        state_n = state;
        mcnt_n  = mcnt;
        frame_n = 1'b0;
        if (lost) begin
            state_n = SEARCH;
            mcnt_n  = '0;
        end else if (vs_edge) begin
            case (state)
                SEARCH: begin
                    // This edge only opens the first complete frame.
                    state_n = MEASURE;
                    mcnt_n  = '0;
                end
                MEASURE: begin
                    frame_n = 1'b1;
                    if (frame_match) begin
                        mcnt_n = mcnt + 4'd1;
                        if (mcnt + 4'd1 >= LF)
                            state_n = LOCKED;
                    end else begin
                        mcnt_n = '0;
                    end
                end
                LOCKED: begin
                    frame_n = 1'b1;
                    if (!frame_match) begin
                        state_n = SEARCH;
                        mcnt_n  = '0;
                    end
                end
                default: begin
                    state_n = SEARCH;
                    mcnt_n  = '0;
                end
            endcase
        end
    end

    // ---------------- lit pixel counter ----------------
`ifdef VGA_SYNC_ANALYZER_PIXCNT_EN
    logic        lit_r;
    logic [18:0] pix;

    // Colour is registered alongside the syncs so both share one timeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lit_r    <= 1'b0;
            pix      <= '0;
            pixcnt_o <= '0;
        end else begin
            lit_r <= red_i | green_i | blue_i;
            if (vs_edge) begin
                pixcnt_o <= pix;
                pix      <= '0;
            end else if (lit_r && !hs_r && !vs_r && pix != 19'h7FFFF) begin
                pix <= pix + 19'd1;
            end
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = red_i ^ green_i ^ blue_i;
    assign pixcnt_o   = '0;
`endif

endmodule
